// File: rtl/id_stage.sv
`timescale 1ns/1ps
// id_stage -- decode stage of a MIPS-style pipeline, directly after fetch.
//
// Accepts one instruction per cycle from fetch over a valid/allowin
// handshake. It latches the instruction with its PC, NPC (PC+4) and
// NNPC (PC+8). It reads the register file through combinational addresses
// and stalls on a load-use hazard against the instruction in EX. Branches
// and jumps are resolved here and the redirect goes back to fetch. The
// delay slot is never squashed.
//
// Optional feature: define ID_RI_EXC_EN to add the id_ri_exc output, which
// flags unsupported encodings. Without it those encodings decode as a NOP.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_valid/if_inst/if_pc/if_npc/if_nnpc   instruction offered by fetch
//   id_allowin               decode can accept an instruction this cycle
//   ex_allowin               execute can accept the decoded bundle
//   ex_is_load/ex_dest       load-use hazard information from EX
//   rf_raddr1/rf_raddr2      register file read addresses (rs, rt)
//   rf_rdata1/rf_rdata2      forwarded register values
//   brcal_out/bjpc_out       taken redirect and its target, back to fetch
//   id_to_ex_valid, id_pc, id_inst, id_rs_value, id_rt_value, id_imm,
//   id_dest, id_link_value   decoded bundle toward EX
//   id_ri_exc                (ID_RI_EXC_EN only) reserved-instruction flag
module id_stage #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] RESET_INST = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_npc,
  input  logic [31:0] if_nnpc,
  output logic        id_allowin,
  input  logic        ex_allowin,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dest,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        brcal_out,
  output logic [31:0] bjpc_out,
  output logic        id_to_ex_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_rs_value,
  output logic [31:0] id_rt_value,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic [31:0] id_link_value
`ifdef ID_RI_EXC_EN
  ,
  output logic        id_ri_exc
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                         OP_SLTI    = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI    = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW      = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL = 6'h02, FN_SRA  = 6'h03,
                         FN_JR   = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  logic        id_valid;
  logic [31:0] inst_q, pc_q, npc_q, nnpc_q;
  logic        id_ready_go;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  assign opcode = inst_q[31:26];
  assign funct  = inst_q[5:0];
  assign rs     = inst_q[25:21];
  assign rt     = inst_q[20:16];
  assign rd     = inst_q[15:11];

  // Pipeline register. A stalled or blocked instruction simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      id_valid <= 1'b0;
      inst_q   <= RESET_INST;
      pc_q     <= RESET_PC;
      npc_q    <= RESET_PC + 32'd4;
      nnpc_q   <= RESET_PC + 32'd8;
    end else if (id_allowin) begin
      id_valid <= if_valid;
      if (if_valid) begin
        inst_q <= if_inst;
        pc_q   <= if_pc;
        npc_q  <= if_npc;
        nnpc_q <= if_nnpc;
      end
    end
  end

  // Instruction class decode.
  logic        supported, uses_rt, is_beq, is_bne, is_jump, is_jr;
  logic [4:0]  dest_raw;
  logic [31:0] imm_ext;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    supported = 1'b0;
    uses_rt   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_jr     = 1'b0;
    dest_raw  = 5'd0;
    imm_ext   = {{16{inst_q[15]}}, inst_q[15:0]};
    case (opcode)
      OP_SPECIAL: begin
        uses_rt   = 1'b1;
        dest_raw  = rd;
        is_jr     = (funct == FN_JR);
        supported = funct inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADDU, FN_SUBU,
                                  FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
      end
      OP_J:   begin supported = 1'b1; is_jump = 1'b1; end
      OP_JAL: begin supported = 1'b1; is_jump = 1'b1; dest_raw = 5'd31; end
      OP_BEQ: begin supported = 1'b1; is_beq = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin supported = 1'b1; is_bne = 1'b1; uses_rt = 1'b1; end
      OP_ADDIU, OP_SLTI, OP_LW: begin supported = 1'b1; dest_raw = rt; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        supported = 1'b1;
        dest_raw  = rt;
        imm_ext   = {16'h0000, inst_q[15:0]};
      end
      OP_LUI: begin
        supported = 1'b1;
        dest_raw  = rt;
        imm_ext   = {inst_q[15:0], 16'h0000};
      end
      OP_SW:  begin supported = 1'b1; uses_rt = 1'b1; end
      default: ;
    endcase
  end

  // A load in EX cannot forward to us this cycle; wait one cycle for it.
  assign id_ready_go = !(id_valid && ex_is_load && (ex_dest != 5'd0) &&
                         ((ex_dest == rs) || (uses_rt && (ex_dest == rt))));
  assign id_allowin     = !id_valid || (id_ready_go && ex_allowin);
  assign id_to_ex_valid = id_valid && id_ready_go;

  // Branch resolution. brcal_out stays high for as long as the branch sits
  // in decode ready to go, so a blocked EX keeps the redirect asserted.
  logic        taken;
  logic [31:0] target;

  always_comb begin
    taken  = 1'b0;
    target = npc_q;
    if (is_beq && (rf_rdata1 == rf_rdata2)) begin
      taken  = 1'b1;
      target = npc_q + {imm_ext[29:0], 2'b00};
    end else if (is_bne && (rf_rdata1 != rf_rdata2)) begin
      taken  = 1'b1;
      target = npc_q + {imm_ext[29:0], 2'b00};
    end else if (is_jump) begin
      taken  = 1'b1;
      target = {npc_q[31:28], inst_q[25:0], 2'b00};
    end else if (supported && is_jr) begin
      taken  = 1'b1;
      target = rf_rdata1;
    end
  end

  assign brcal_out = id_to_ex_valid && taken;
  assign bjpc_out  = brcal_out ? target : npc_q;

  assign rf_raddr1     = rs;
  assign rf_raddr2     = rt;
  assign id_pc         = pc_q;
  assign id_inst       = inst_q;
  assign id_rs_value   = rf_rdata1;
  assign id_rt_value   = rf_rdata2;
  assign id_imm        = imm_ext;
  assign id_link_value = nnpc_q;
  // Unsupported encodings and jr write nothing back.
  assign id_dest       = (supported && !is_jr) ? dest_raw : 5'd0;

`ifdef ID_RI_EXC_EN
  assign id_ri_exc = id_to_ex_valid && !supported;
`endif

endmodule

// File: tb/tb_id_stage.sv
`timescale 1ns/1ps
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst, if_pc, if_npc, if_nnpc;
  logic        id_allowin;
  logic        ex_allowin, ex_is_load;
  logic [4:0]  ex_dest;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        brcal_out;
  logic [31:0] bjpc_out;
  logic        id_to_ex_valid;
  logic [31:0] id_pc, id_inst, id_rs_value, id_rt_value, id_imm, id_link_value;
  logic [4:0]  id_dest;
`ifdef ID_RI_EXC_EN
  logic        id_ri_exc;
`endif

  id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_npc(if_npc), .if_nnpc(if_nnpc),
    .id_allowin(id_allowin), .ex_allowin(ex_allowin),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .brcal_out(brcal_out), .bjpc_out(bjpc_out),
    .id_to_ex_valid(id_to_ex_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs_value(id_rs_value), .id_rt_value(id_rt_value),
    .id_imm(id_imm), .id_dest(id_dest), .id_link_value(id_link_value)
`ifdef ID_RI_EXC_EN
    , .id_ri_exc(id_ri_exc)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_if(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    if_valid = v;
    if_inst  = inst;
    if_pc    = pc;
    if_npc   = pc + 32'd4;
    if_nnpc  = pc + 32'd8;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (rules of the ISA subset) ----------------
  typedef struct {
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        taken;
    logic [31:0] target;
    logic        uses_rt;
    logic        known;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] inst, input logic [31:0] npc,
                                      input logic [31:0] a, input logic [31:0] b);
    ref_t r;
    logic [5:0]  op = inst[31:26];
    logic [5:0]  fn = inst[5:0];
    logic [15:0] i16 = inst[15:0];
    r.imm = {{16{i16[15]}}, i16};
    if (op inside {6'h0C, 6'h0D, 6'h0E}) r.imm = {16'h0000, i16};
    if (op == 6'h0F) r.imm = {i16, 16'h0000};
    if (op == 6'h00)
      r.known = fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h21, 6'h23,
                           6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    else
      r.known = op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0C,
                           6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    r.uses_rt = (op == 6'h00) || (op inside {6'h04, 6'h05, 6'h2B});
    r.dest = 5'd0;
    if (r.known) begin
      if (op == 6'h00 && fn != 6'h08) r.dest = inst[15:11];
      else if (op inside {6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) r.dest = inst[20:16];
      else if (op == 6'h03) r.dest = 5'd31;
    end
    r.taken  = 1'b0;
    r.target = npc;
    if ((op == 6'h04 && a == b) || (op == 6'h05 && a != b)) begin
      r.taken  = 1'b1;
      r.target = npc + r.imm * 4;
    end else if (op == 6'h02 || op == 6'h03) begin
      r.taken  = 1'b1;
      r.target = (npc & 32'hF000_0000) + 32'(inst[25:0]) * 4;
    end else if (op == 6'h00 && fn == 6'h08) begin
      r.taken  = 1'b1;
      r.target = a;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs = 5'($urandom_range(0, 7));
    logic [4:0]  rt = 5'($urandom_range(0, 7));
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [15:0] im = 16'($urandom);
    case ($urandom_range(0, 15))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      2:  return {6'h00, 5'd0, rt, rd, 5'd3, 6'h00};
      3:  return {6'h00, rs, 15'd0, 6'h08};
      4:  return {6'h02, 26'($urandom)};
      5:  return {6'h03, 26'($urandom)};
      6:  return {6'h04, rs, rt, im};
      7:  return {6'h05, rs, rt, im};
      8:  return {6'h09, rs, rt, im};
      9:  return {6'h0C, rs, rt, im};
      10: return {6'h0D, rs, rt, im};
      11: return {6'h0F, 5'd0, rt, im};
      12: return {6'h23, rs, rt, im};
      13: return {6'h2B, rs, rt, im};
      14: return {6'h0A, rs, rt, im};
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, rs, rt, im}
                                                  : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    endcase
  endfunction

  typedef struct {
    logic        valid;
    logic [31:0] inst, pc, npc, nnpc;
  } mstate_t;

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        brcal;
    logic [31:0] bjpc;
    logic [4:0]  raddr1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    rst = 1'b1;
    drive_if(1'b0, 32'h0, 32'h0);
    ex_allowin = 1'b1;
    ex_is_load = 1'b0;
    ex_dest    = 5'd0;
    rf_rdata1  = 32'h0;
    rf_rdata2  = 32'h0;

    //          inst          pc            rs_val        rt_val        imm           dest br bjpc          ra1
    vecs[0]  = '{32'h2422FFFF, 32'hBFC00000, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd2,  1'b0, 32'hBFC00004, 5'd1};
    vecs[1]  = '{32'h10220004, 32'hBFC00010, 32'h5,        32'h5,        32'h00000004, 5'd0,  1'b1, 32'hBFC00024, 5'd1};
    vecs[2]  = '{32'h10220004, 32'hBFC00010, 32'h5,        32'h6,        32'h00000004, 5'd0,  1'b0, 32'hBFC00014, 5'd1};
    vecs[3]  = '{32'h0C100000, 32'hBFC00020, 32'h0,        32'h0,        32'h00000000, 5'd31, 1'b1, 32'hB0400000, 5'd0};
    vecs[4]  = '{32'h1464FFFE, 32'h00001000, 32'h1,        32'h2,        32'hFFFFFFFE, 5'd0,  1'b1, 32'h00000FFC, 5'd3};
    vecs[5]  = '{32'h34C58001, 32'h00002000, 32'h0,        32'h0,        32'h00008001, 5'd5,  1'b0, 32'h00002004, 5'd6};
    vecs[6]  = '{32'h3C071234, 32'h00002010, 32'h0,        32'h0,        32'h12340000, 5'd7,  1'b0, 32'h00002014, 5'd0};
    vecs[7]  = '{32'h00652021, 32'h00002020, 32'h0,        32'h0,        32'h00002021, 5'd4,  1'b0, 32'h00002024, 5'd3};
    vecs[8]  = '{32'h03E00008, 32'h00002030, 32'h80001234, 32'h0,        32'h00000008, 5'd0,  1'b1, 32'h80001234, 5'd31};
    vecs[9]  = '{32'hAC220004, 32'h00002040, 32'h0,        32'h0,        32'h00000004, 5'd0,  1'b0, 32'h00002044, 5'd1};
    vecs[10] = '{32'h8C29FFF8, 32'h00002050, 32'h0,        32'h0,        32'hFFFFFFF8, 5'd9,  1'b0, 32'h00002054, 5'd1};
    vecs[11] = '{32'hFC22FFFF, 32'h00002060, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd0,  1'b0, 32'h00002064, 5'd1};
    vecs[12] = '{32'h3028FFFF, 32'h00002070, 32'h0,        32'h0,        32'h0000FFFF, 5'd8,  1'b0, 32'h00002074, 5'd1};
    vecs[13] = '{32'h0BFFFFFF, 32'hBFC00030, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd0,  1'b1, 32'hBFFFFFFC, 5'd31};

    // ---- reset state ----
    #2;
    check("rst_to_ex", id_to_ex_valid, 1'b0);
    check("rst_brcal", brcal_out, 1'b0);
    check("rst_dest", id_dest, 5'd0);
    check("rst_pc", id_pc, 32'hBFC00000);
    check("rst_inst", id_inst, 32'h0);
    check("rst_link", id_link_value, 32'hBFC00008);
    check("rst_allowin", id_allowin, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---- table-driven decode vectors ----
    for (int i = 0; i < NV; i++) begin
      drive_if(1'b1, vecs[i].inst, vecs[i].pc);
      tick();
      drive_if(1'b0, 32'h0, 32'h0);
      rf_rdata1 = vecs[i].rs_val;
      rf_rdata2 = vecs[i].rt_val;
      #1;
      check($sformatf("v%0d_to_ex", i), id_to_ex_valid, 1'b1);
      check($sformatf("v%0d_imm", i), id_imm, vecs[i].imm);
      check($sformatf("v%0d_dest", i), id_dest, vecs[i].dest);
      check($sformatf("v%0d_brcal", i), brcal_out, vecs[i].brcal);
      check($sformatf("v%0d_bjpc", i), bjpc_out, vecs[i].bjpc);
      check($sformatf("v%0d_raddr1", i), rf_raddr1, vecs[i].raddr1);
      check($sformatf("v%0d_raddr2", i), rf_raddr2, vecs[i].inst[20:16]);
      check($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
      check($sformatf("v%0d_link", i), id_link_value, vecs[i].pc + 32'd8);
      check($sformatf("v%0d_rsval", i), id_rs_value, vecs[i].rs_val);
    end
    tick();
    check("drain_to_ex", id_to_ex_valid, 1'b0);

    // ---- load-use stall: addu $4,$3,$5 behind lw $3 ----
    drive_if(1'b1, 32'h00652021, 32'h00003000);
    tick();
    ex_is_load = 1'b1;
    ex_dest    = 5'd3;
    drive_if(1'b1, 32'h2422FFFF, 32'h00003004);
    #1;
    check("lu_to_ex", id_to_ex_valid, 1'b0);
    check("lu_allowin", id_allowin, 1'b0);
    ex_dest = 5'd5; #1;
    check("lu_rt_to_ex", id_to_ex_valid, 1'b0);
    ex_dest = 5'd0; #1;
    check("lu_r0_to_ex", id_to_ex_valid, 1'b1);
    ex_dest = 5'd3; #1;
    tick();
    check("lu_hold_inst", id_inst, 32'h00652021);
    ex_is_load = 1'b0;
    #1;
    check("lu_release_to_ex", id_to_ex_valid, 1'b1);
    check("lu_release_allowin", id_allowin, 1'b1);
    tick();
    drive_if(1'b0, 32'h0, 32'h0);
    check("lu_next_inst", id_inst, 32'h2422FFFF);
    ex_is_load = 1'b1;
    ex_dest    = 5'd2;
    #1;
    check("lu_addiu_rt_no_stall", id_to_ex_valid, 1'b1);
    ex_is_load = 1'b0;
    tick();

    // ---- branch depending on a load: stall, then resolve ----
    drive_if(1'b1, 32'h10220004, 32'hBFC00010);
    tick();
    drive_if(1'b0, 32'h0, 32'h0);
    ex_is_load = 1'b1;
    ex_dest    = 5'd1;
    rf_rdata1  = 32'h1111;
    rf_rdata2  = 32'h2222;
    #1;
    check("bl_stall_brcal", brcal_out, 1'b0);
    check("bl_stall_to_ex", id_to_ex_valid, 1'b0);
    tick();
    ex_is_load = 1'b0;
    rf_rdata1  = 32'h2222;
    #1;
    check("bl_resolve_brcal", brcal_out, 1'b1);
    check("bl_resolve_bjpc", bjpc_out, 32'hBFC00024);
    tick();

    // ---- EX blocked for 3 cycles with a taken beq in decode ----
    drive_if(1'b1, 32'h10220004, 32'hBFC00010);
    rf_rdata1 = 32'h7;
    rf_rdata2 = 32'h7;
    tick();
    ex_allowin = 1'b0;
    drive_if(1'b1, 32'h2422FFFF, 32'h00000100);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("blk%0d_brcal", c), brcal_out, 1'b1);
      check($sformatf("blk%0d_allowin", c), id_allowin, 1'b0);
      check($sformatf("blk%0d_pc", c), id_pc, 32'hBFC00010);
      check($sformatf("blk%0d_bjpc", c), bjpc_out, 32'hBFC00024);
      tick();
    end
    ex_allowin = 1'b1;
    #1;
    check("blk_leave_brcal", brcal_out, 1'b1);
    check("blk_leave_allowin", id_allowin, 1'b1);
    tick();
    drive_if(1'b0, 32'h0, 32'h0);
    check("blk_after_brcal", brcal_out, 1'b0);
    check("blk_after_pc", id_pc, 32'h00000100);
    tick();

    // ---- randomized run against the reference model ----
    begin
      mstate_t m, mn;
      ref_t    r;
      logic    rdy, allow, to_ex;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      m = '{1'b0, 32'h0, 32'hBFC00000, 32'hBFC00004, 32'hBFC00008};
      tick();
      for (int i = 0; i < 400; i++) begin
        drive_if(1'($urandom_range(0, 3) != 0), rand_inst(), $urandom() & 32'hFFFF_FFFC);
        ex_allowin = 1'($urandom_range(0, 3) != 0);
        ex_is_load = 1'($urandom_range(0, 1));
        ex_dest    = 5'($urandom_range(0, 7));
        rf_rdata1  = $urandom();
        rf_rdata2  = ($urandom_range(0, 1) == 0) ? rf_rdata1 : $urandom();
        #1;
        r     = ref_decode(m.inst, m.npc, rf_rdata1, rf_rdata2);
        rdy   = !(m.valid && ex_is_load && ex_dest != 0 &&
                  (ex_dest == m.inst[25:21] || (r.uses_rt && ex_dest == m.inst[20:16])));
        allow = !m.valid || (rdy && ex_allowin);
        to_ex = m.valid && rdy;
        check("rnd_allowin", id_allowin, allow);
        check("rnd_to_ex", id_to_ex_valid, to_ex);
        check("rnd_brcal", brcal_out, to_ex && r.taken);
        check("rnd_bjpc", bjpc_out, (to_ex && r.taken) ? r.target : m.npc);
        check("rnd_dest", id_dest, r.dest);
        check("rnd_imm", id_imm, r.imm);
        check("rnd_pc", id_pc, m.pc);
        check("rnd_raddr", {rf_raddr1, rf_raddr2}, {m.inst[25:21], m.inst[20:16]});
`ifdef ID_RI_EXC_EN
        check("rnd_ri_exc", id_ri_exc, to_ex && !r.known);
`endif
        mn = m;
        if (allow) begin
          mn.valid = if_valid;
          if (if_valid) mn = '{1'b1, if_inst, if_pc, if_npc, if_nnpc};
        end
        @(posedge clk);
        m = mn;
        #1;
      end
    end

    // ---- reset asserted mid-run with a valid instruction held ----
    ex_allowin = 1'b1;
    ex_is_load = 1'b0;
    drive_if(1'b1, 32'h10220004, 32'h00004000);
    rf_rdata1 = 32'h9;
    rf_rdata2 = 32'h9;
    tick();
    drive_if(1'b0, 32'h0, 32'h0);
    #1;
    check("mid_pre_to_ex", id_to_ex_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_to_ex", id_to_ex_valid, 1'b0);
    check("mid_rst_pc", id_pc, 32'hBFC00000);
    check("mid_rst_brcal", brcal_out, 1'b0);
    check("mid_rst_allowin", id_allowin, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // ---- reset during a load-use stall discards the held instruction ----
    drive_if(1'b1, 32'h00652021, 32'h00005000);
    tick();
    drive_if(1'b0, 32'h0, 32'h0);
    ex_is_load = 1'b1;
    ex_dest    = 5'd3;
    #1;
    check("mstall_allowin", id_allowin, 1'b0);
    rst = 1'b1;
    #1;
    check("mstall_rst_allowin", id_allowin, 1'b1);
    check("mstall_rst_to_ex", id_to_ex_valid, 1'b0);
    check("mstall_rst_inst", id_inst, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ex_is_load = 1'b0;
    tick();
    check("mstall_after_to_ex", id_to_ex_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
